// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues (op, len) commands and replays each on registered j/k
// for len+1 clocks, back-to-back, with a built-in model of the downstream JK flop.
`default_nettype none

module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             q_model
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       op_mem  [DEPTH];
  logic [CNT_W-1:0] len_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [CNT_W-1:0] remain, remain_nxt;
  logic [1:0]       jk_nxt;
  logic             done_nxt;
  logic             push, pop, full, empty;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state == RUN) || !empty;

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]  <= cmd_op;
      len_mem[wr_ptr] <= cmd_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    pop        = 1'b0;
    state_nxt  = state;
    remain_nxt = remain;
    jk_nxt     = {j, k};
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        jk_nxt = 2'b00;
        if (!empty) begin
          pop        = 1'b1;
          remain_nxt = len_mem[rd_ptr];
          jk_nxt     = op_mem[rd_ptr];
          state_nxt  = RUN;
        end
      end
      RUN: begin
        if (remain != '0) begin
          remain_nxt = remain - CNT_W'(1);
        end else if (!empty) begin
          // Chain straight into the next command so j/k never drop to 00 between them.
          pop        = 1'b1;
          remain_nxt = len_mem[rd_ptr];
          jk_nxt     = op_mem[rd_ptr];
        end else begin
          jk_nxt    = 2'b00;
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      remain <= '0;
      j      <= 1'b0;
      k      <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      remain <= remain_nxt;
      {j, k} <= jk_nxt;
      done   <= done_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_model <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q_model <= 1'b0;
        2'b10:   q_model <= 1'b1;
        2'b11:   q_model <= ~q_model;
        default: q_model <= q_model;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jk_cmd_sequencer.sv
// Scoreboard bench for jk_cmd_sequencer: accepted commands expand into per-cycle
// expected j/k entries; a monitor consumes them every clock and checks all outputs.
`default_nettype none

module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_len = '0;
  logic             j, k, busy, done, q_model;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .j(j), .k(k),
    .busy(busy), .done(done), .q_model(q_model)
  );

  always #5 clk = ~clk;

  // One entry per clock of output; 'first' marks a command still sitting in the FIFO.
  typedef struct {
    logic [1:0] op;
    bit         first;
    int         cyc;
  } ent_t;

  ent_t       exp_q[$];
  int         cyc = 0;
  int         n_total = 0;
  int         n_pass = 0;
  logic [1:0] m_jk = 2'b00;
  bit         m_act = 1'b0;
  bit         m_q = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  function automatic int fifo_cnt();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].first) n++;
    return n;
  endfunction

  // Monitor: after each edge, advance the reference and compare every output.
  initial begin
    ent_t e;
    bit   prev_act;
    int   cnt;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        m_jk  = 2'b00;
        m_act = 1'b0;
        m_q   = 1'b0;
        chk("reset_j", j, 0);
        chk("reset_k", k, 0);
        chk("reset_q_model", q_model, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
      end else begin
        case (m_jk)
          2'b01:   m_q = 1'b0;
          2'b10:   m_q = 1'b1;
          2'b11:   m_q = !m_q;
          default: ;
        endcase
        prev_act = m_act;
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e     = exp_q.pop_front();
          m_jk  = e.op;
          m_act = 1'b1;
        end else begin
          m_jk  = 2'b00;
          m_act = 1'b0;
        end
        cnt = fifo_cnt();
        chk("j", j, m_jk[1]);
        chk("k", k, m_jk[0]);
        chk("q_model", q_model, m_q);
        chk("done", done, (prev_act && !m_act) ? 1 : 0);
        chk("busy", busy, (m_act || cnt > 0) ? 1 : 0);
        chk("cmd_ready", cmd_ready, (cnt < DEPTH) ? 1 : 0);
      end
    end
  end

  // Called at a negedge; leaves cmd_valid high so pushes can be issued on consecutive edges.
  task automatic push_cmd(input logic [1:0] op, input int len);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = CNT_W'(len);
    while (fifo_cnt() >= DEPTH && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      chk("push_timeout", 1, 0);
    end else begin
      for (int i = 0; i <= len; i++)
        exp_q.push_back('{op: op, first: (i == 0), cyc: cyc + 1});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_len   = CNT_W'($urandom_range(0, 15));
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    cmd_valid = 1'b0;
    while ((exp_q.size() != 0 || m_act) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("drain_in_time", (t < 400) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // Asynchronous reset between edges, with a command offered that must be ignored.
  task automatic pulse_reset();
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_len   = CNT_W'(5);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("async_rst_j", j, 0);
    chk("async_rst_k", k, 0);
    chk("async_rst_q_model", q_model, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_cmd_ready", cmd_ready, 1);
    chk("async_rst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single set, len 0.
    push_cmd(2'b10, 0);
    drain();

    // Clear q, then toggle for 3 cycles.
    push_cmd(2'b01, 0);
    drain();
    push_cmd(2'b11, 2);
    drain();

    // Back-to-back pushes that overfill the FIFO.
    push_cmd(2'b10, 0);
    push_cmd(2'b01, 3);
    push_cmd(2'b11, 1);
    push_cmd(2'b00, 0);
    push_cmd(2'b10, 2);
    push_cmd(2'b11, 0);
    drain();

    // Reset during a long toggle with two commands queued behind it.
    push_cmd(2'b11, 15);
    push_cmd(2'b10, 1);
    push_cmd(2'b01, 2);
    idle(5);
    pulse_reset();
    idle(6);
    drain();

    // Randomized traffic with one reset in the middle.
    for (int it = 0; it < 200; it++) begin
      if (it == 120) pulse_reset();
      if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(1, 4));
      end else begin
        push_cmd(2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2));
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jk_cmd_sequencer.md
# jk_cmd_sequencer

Command-driven stimulus stage that sits directly upstream of the JK flip-flop and drives its `j`/`k` inputs. Software or a bench pushes (operation, cycle-count) commands through a valid/ready handshake into a small FIFO. An FSM replays each command on registered `j`/`k` outputs for the requested number of clocks, back-to-back with no gaps. A built-in reference model `q_model` tracks the value the downstream flop's `q` must hold, so benches can compare against it directly.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of 2, ≥2.
- `CNT_W`, 4: width of the cycle-count field.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; equals `!full`.
- `cmd_op`  in  2  00 hold, 01 reset, 10 set, 11 toggle; this is the {j,k} pair.
- `cmd_len`  in  CNT_W  command lasts `cmd_len+1` clocks (0 → 1 clock, max 2^CNT_W).
- `j`  out  1  registered J drive to the flop.
- `k`  out  1  registered K drive to the flop.
- `busy`  out  1  FSM in RUN, or FIFO non-empty.
- `done`  out  1  one-cycle pulse when the last queued command completes.
- `q_model`  out  1  expected flop output.

## Operation
- Accept: a push occurs on an edge where `cmd_valid && cmd_ready`. {op,len} is written at the write pointer.
- FIFO: read and write pointers wrap modulo DEPTH. An occupancy counter of width log2(DEPTH)+1 gives `full` (count==DEPTH) and `empty`.
  - Push and pop on the same edge leave the count unchanged.
  - Push is impossible when full, because `cmd_ready`=0.
- FSM states:
  - IDLE: `j`=`k`=0. If the FIFO is non-empty, pop, load `cur_op`/`remain=len`, drive `{j,k}<=op`, and go to RUN.
  - RUN: each edge with `remain`≠0 decrements `remain`. On the edge with `remain`==0 (last cycle ends):
    - If the FIFO is non-empty: pop the next command, load it, drive the new op immediately. State stays RUN; there is no idle cycle between commands.
    - If the FIFO is empty: `{j,k}<=00`, state goes to IDLE, `done<=1` for one cycle.
- `q_model` updates on each edge from the current registered `j`,`k`: 00 hold, 01 →0, 10 →1, 11 invert. It therefore mirrors the flop fed by `j`/`k`.
- `busy` is combinational: `(state==RUN) | !empty`.
- The FSM is the only consumer of the FIFO. A command pushed into an empty FIFO while IDLE is popped on the following edge.

## Timing
- Reset values: `j`=0, `k`=0, `q_model`=0, `done`=0, `busy`=0, `cmd_ready`=1. State is IDLE, pointers and count are 0.
- Latency from an accepted push on edge N (FSM IDLE, FIFO empty):
  - Edge N+1: pop; `j`/`k` show the op after this edge.
  - The op is held through edges N+2 … N+1+len+1; the downstream flop samples it on those edges.
  - `q_model` reflects the first application after edge N+2.
- The occupancy count reaches 0 after edge N+1, so `cmd_ready` is never lowered by a single command.
- Capacity: DEPTH commands queued plus one executing in the FSM.
- After the final command, `done` is high for exactly the one cycle following the edge that returns `j`/`k` to 00. `busy` falls on that same edge.
- Reset mid-operation:
  - Asserting `rst` forces all reset values immediately (asynchronous), including `q_model`.
  - Queued commands are discarded.
  - Operation resumes on the first edge after deassertion.
- A `cmd_valid` present during reset is ignored.

## Test plan
- Reset: assert `rst` between edges → `j`=`k`=0, `q_model`=0, `busy`=0, `cmd_ready`=1 immediately; FIFO empty after release.
- Single set: push op=10, len=0 at edge N → `j`=1,`k`=0 for exactly one cycle after edge N+1; `q_model`=1 from edge N+2; `done` pulses the cycle after edge N+2.
- Toggle run: from `q_model`=0, push op=11, len=2 → `j`=`k`=1 for 3 cycles; `q_model` sequence 1,0,1; then `j`=`k`=0, `done`=1 once.
- Back-to-back/full: push 10/len0, then 01/len3, 11/len1, 00/len0, 10/len2, 11/len0 on consecutive edges → `cmd_ready` drops after the FIFO holds 4 entries; ops appear contiguously with no 00 gap; `q_model` ends at 0; one `done` pulse total.
- Boundary push+pop: with FIFO full, at the edge the FSM pops, also present `cmd_valid` → push is refused that edge (`cmd_ready` was 0). Next edge the push is accepted, count returns to 4, and no command is lost or duplicated.
- Reset mid-run: during a len=15 toggle with 2 commands queued, pulse `rst` → all outputs return to reset values at once; no further `j`/`k` activity; `done` is not asserted.
